bin2bcd_seq: RTL and testbench

//  Iterative binary-to-BCD converter (shift-and-add-3) for the result display path.
//  It sits downstream of the calculator ALU result register and upstream of the

---
 rtl/bin2bcd_seq_if.sv | 15 +
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus for the iterative binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;

  modport master (output start, bin, input busy, done, bcd, neg);
  modport slave  (input start, bin, output busy, done, bcd, neg);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          KEY1,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   shift_reg, shift_n;
  logic [BCD_W-1:0]   scratch, scratch_n;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BCD_W-1:0]   bcd_reg, bcd_n;
  logic               done_reg, done_n;
  logic [WIDTH-1:0]   mag;

`ifdef BIN2BCD_SIGNED_EN
  logic bin_neg;
  logic sign_reg, sign_n;
  logic neg_reg, neg_n;

  assign bin_neg = bus.bin[WIDTH-1];
  assign mag     = bin_neg ? (~bus.bin + WIDTH'(1)) : bus.bin;

  // Sign is latched with the operand and published only on the completing edge.
  always_comb begin
    sign_n = sign_reg;
    neg_n  = neg_reg;
    if (state == IDLE && bus.start)
      sign_n = bin_neg;
    if (state == SHIFT && cnt == CNT_W'(1))
      neg_n = sign_reg;
  end

  always_ff @(posedge clk or negedge KEY1) begin
    if (!KEY1) begin
      sign_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else begin
      sign_reg <= sign_n;
      neg_reg  <= neg_n;
    end
  end

  assign bus.neg = neg_reg;
`else
  assign mag     = bus.bin;
  assign bus.neg = 1'b0;
`endif

  always_ff @(posedge clk or negedge KEY1) begin
    if (!KEY1) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      scratch   <= scratch_n;
      cnt       <= cnt_n;
      bcd_reg   <= bcd_n;
      done_reg  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    scratch_n = scratch;
    cnt_n     = cnt;
    bcd_n     = bcd_reg;
    done_n    = 1'b0;
    adj       = scratch;

    case (state)
      IDLE: begin
        if (bus.start) begin
          shift_n   = mag;
          scratch_n = '0;
          cnt_n     = CNT_W'(WIDTH);
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        // Digit correction happens before the shift so each digit stays valid BCD after doubling.
        for (int d = 0; d < DIGITS; d++) begin
          if (adj[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        scratch_n = {adj[BCD_W-2:0], shift_reg[WIDTH-1]};
        shift_n   = {shift_reg[WIDTH-2:0], 1'b0};
        cnt_n     = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_n   = scratch_n;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_reg;
  assign bus.bcd  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random back-to-back conversions.
module tb_bin2bcd_seq;

  logic clk;
  logic KEY1;
  int   checks;
  int   failures;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk  (clk),
    .KEY1 (KEY1),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by repeated division; returns {neg, bcd}.
  function automatic logic [20:0] refModel(input logic [15:0] v);
    int         mag;
    logic       n;
    logic [19:0] r;
`ifdef BIN2BCD_SIGNED_EN
    n   = v[15];
    mag = n ? (65536 - int'(v)) : int'(v);
`else
    n   = 1'b0;
    mag = int'(v);
`endif
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {n, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the done edge.
  task automatic applyStimulus(input logic [15:0] value, input int injectCycle);
    logic [20:0] expected;
    logic [19:0] heldBcd;
    logic        heldNeg;
    logic        held;
    int          cycles;
    int          busyHigh;
    expected = refModel(value);
    heldBcd  = bus.bcd;
    heldNeg  = bus.neg;
    held     = 1'b1;
    bus.start = 1'b1;
    bus.bin   = value;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = 16'($urandom);
    cycles   = 0;
    busyHigh = 0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busyHigh++;
      if (bus.bcd !== heldBcd || bus.neg !== heldNeg) held = 1'b0;
      if (cycles == injectCycle) begin
        bus.start = 1'b1;
        bus.bin   = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
    checkOutput("latency", 32'(cycles), 32'd16);
    checkOutput("busy_span", 32'(busyHigh), 32'd16);
    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    checkOutput("result_hold", 32'(held), 32'd1);
    checkOutput("bcd", 32'(bus.bcd), 32'(expected[19:0]));
    checkOutput("neg", 32'(bus.neg), 32'(expected[20]));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int          doneSeen;
    logic [19:0] lastBcd;
    logic [15:0] v;
    logic [15:0] corner[6];
    checks   = 0;
    failures = 0;
    KEY1      = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_bcd", 32'(bus.bcd), 32'd0);
    checkOutput("reset_neg", 32'(bus.neg), 32'd0);
    #3 KEY1 = 1'b1;
    @(posedge clk); #1;

    applyStimulus(16'd0, -1);
    applyStimulus(16'hFFFF, -1);
    applyStimulus(16'h04D2, -1);
    applyStimulus(16'd999, 5);
    applyStimulus(16'd42, -1);

    // No spurious done and stable result while idle.
    doneSeen = 0;
    lastBcd  = bus.bcd;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) doneSeen++;
    end
    checkOutput("idle_no_done", 32'(doneSeen), 32'd0);
    checkOutput("idle_bcd_hold", 32'(bus.bcd), 32'(lastBcd));
    checkOutput("idle_bcd_value", 32'(bus.bcd), 32'h00042);

    // Abort a conversion with an asynchronous reset.
    bus.start = 1'b1;
    bus.bin   = 16'd5000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    KEY1 = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_bcd", 32'(bus.bcd), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    doneSeen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) doneSeen++;
    end
    #2 KEY1 = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(16'd5000, -1);

    corner[0] = 16'hFFFF;
    corner[1] = 16'h8000;
    corner[2] = 16'h7FFF;
    corner[3] = 16'd9999;
    corner[4] = 16'd10000;
    corner[5] = 16'd1;
    foreach (corner[i]) applyStimulus(corner[i], -1);

    for (int n = 0; n < 150; n++) begin
      v = 16'($urandom);
      applyStimulus(v, (n % 4 == 0) ? int'($urandom_range(0, 15)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
